mov_unit: RTL and testbench



---
 rtl/mix_pkg.sv | 15 +
 rtl/mov_unit_if.sv | 38 +++
 rtl/mov_unit.sv | 95 +++++++++
 tb/tb_mov_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - MIX memory-map widths and MOVE sequencer state encoding
package mix_pkg;

  localparam int ADDR_W    = 12;
  localparam int MEM_WORDS = 4000;
  localparam int LEN_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STORE  = 2'd2,
    ST_FINISH = 2'd3
  } mov_state_e;

endpackage

// File: rtl/mov_unit_if.sv
// rtl/mov_unit_if.sv - MOVE request and memory-strobe bundle (fault only with MOV_RANGE_CHECK_EN)
interface mov_unit_if;
  import mix_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] addressin;
  logic [ADDR_W-1:0] destin;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] addressout;
  logic              load;
  logic              store;
  logic              busy;
  logic              done;
`ifdef MOV_RANGE_CHECK_EN
  logic              fault;

  modport master (
    output start, addressin, destin, len,
    input  addressout, load, store, busy, done, fault
  );

  modport slave (
    input  start, addressin, destin, len,
    output addressout, load, store, busy, done, fault
  );
`else
  modport master (
    output start, addressin, destin, len,
    input  addressout, load, store, busy, done
  );

  modport slave (
    input  start, addressin, destin, len,
    output addressout, load, store, busy, done
  );
`endif

endinterface

// File: rtl/mov_unit.sv
// rtl/mov_unit.sv - MIX MOVE address sequencer: LOAD/STORE strobe pairs, ascending order
// Optional MOV_RANGE_CHECK_EN suppresses strobes above the last memory word and raises fault.
module mov_unit
  import mix_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mov_unit_if.slave bus
);

  mov_state_e        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_count;

  logic [LEN_W-1:0]  w_count_dec;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_load;
  logic              w_in_store;
  logic              w_accept;

  assign w_count_dec = r_count - LEN_W'(1);
  assign w_in_load   = (r_state == ST_LOAD);
  assign w_in_store  = (r_state == ST_STORE);
  assign w_accept    = (r_state == ST_IDLE) && bus.start;
  assign w_addr      = w_in_store ? r_dst : r_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_src   <= bus.addressin;
            r_dst   <= bus.destin;
            r_count <= bus.len;
            r_state <= (bus.len != '0) ? ST_LOAD : ST_FINISH;
          end
        end
        ST_LOAD: begin
          r_state <= ST_STORE;
        end
        ST_STORE: begin
          // Plain 12-bit adds: addresses wrap modulo 4096.
          r_src   <= r_src + ADDR_W'(1);
          r_dst   <= r_dst + ADDR_W'(1);
          r_count <= w_count_dec;
          r_state <= (w_count_dec != '0) ? ST_LOAD : ST_FINISH;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.addressout = w_addr;
  assign bus.busy       = w_in_load | w_in_store;
  assign bus.done       = (r_state == ST_FINISH);

`ifdef MOV_RANGE_CHECK_EN
  logic w_out_of_range;
  logic w_blocked;
  logic r_fault;

  assign w_out_of_range = (w_addr >= ADDR_W'(MEM_WORDS));
  assign w_blocked      = (w_in_load | w_in_store) & w_out_of_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= 1'b0;
    end else if (w_blocked) begin
      r_fault <= 1'b1;
    end
  end

  // Fault shows in the very cycle of the first suppressed strobe, then stays sticky.
  assign bus.load  = w_in_load & ~w_out_of_range;
  assign bus.store = w_in_store & ~w_out_of_range;
  assign bus.fault = r_fault | w_blocked;
`else
  logic w_unused_accept;

  assign w_unused_accept = w_accept;
  assign bus.load        = w_in_load;
  assign bus.store       = w_in_store;
`endif

endmodule

// File: tb/tb_mov_unit.sv
// tb/tb_mov_unit.sv - scoreboard bench for mov_unit with a word-level MOVE reference model
module tb_mov_unit;
  import mix_pkg::*;

  localparam int INF = 32'h3fff_ffff;
`ifdef MOV_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef struct {
    int cyc;
    int kind;
    int addr;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  mov_unit_if bus ();

  mov_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [4096];
  logic [15:0] mem_latch = 16'h0;

  always @(posedge clk) begin
    if (bus.load)  mem_latch <= mem[bus.addressout];
    if (bus.store) mem[bus.addressout] <= mem_latch;
  end

  logic [15:0] exp_mem [4096];
  logic [15:0] model_latch = 16'h0;

  ev_t ev_q[$];
  int  mv_t0 = -100;
  int  mv_len = 0;
  int  mv_fault_from = INF;
  int  mv_abort = INF;
  bit  mon_en = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit blocked(input int a);
    return RANGE_CHECK && (a >= MEM_WORDS);
  endfunction

  // Word-level MOVE: each word is read then written, in ascending order.
  task automatic apply_model(input int src, input int dst, input int nl, input int ns);
    for (int i = 0; i < nl; i++) begin
      int s;
      int d;
      s = (src + i) % 4096;
      d = (dst + i) % 4096;
      if (!blocked(s)) model_latch = exp_mem[s];
      if (i < ns && !blocked(d)) exp_mem[d] = model_latch;
    end
  endtask

  task automatic monitor_cycle();
    int  exp_busy;
    int  kind;
    ev_t e;
    exp_busy = int'((cyc >= mv_t0 + 1) && (cyc <= mv_t0 + 2 * mv_len) && (cyc <= mv_abort));
    check("busy", int'(bus.busy), exp_busy);
`ifdef MOV_RANGE_CHECK_EN
    check("fault", int'(bus.fault), int'((cyc >= mv_fault_from) && (cyc <= mv_abort)));
`endif
    check("load_store_exclusive", int'(bus.load & bus.store), 0);
    if (cyc == mv_abort + 1) check("addr_after_reset", int'(bus.addressout), 0);
    if (bus.load || bus.store || bus.done) begin
      kind = bus.load ? 0 : (bus.store ? 1 : 2);
      check("strobe_expected", int'(ev_q.size() > 0), 1);
      if (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        check("strobe_kind", kind, e.kind);
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_addr", int'(bus.addressout), e.addr);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) monitor_cycle();
    end
  end

  // Called at negedge+1; returns at negedge+1 of the first cycle a new start may be issued.
  task automatic run_move(input int src, input int dst, input int n,
                          input int abort_off, input int mid_off);
    int t0;
    int a;
    int nl;
    int ns;
    int ff;
    int end_cyc;
    int bad;
    t0 = cyc;
    a  = (abort_off >= 0) ? t0 + abort_off : INF;
    nl = 0;
    ns = 0;
    ff = INF;
    for (int i = 0; i < n; i++) begin
      int s;
      int d;
      int lc;
      s  = (src + i) % 4096;
      d  = (dst + i) % 4096;
      lc = t0 + 1 + 2 * i;
      if (lc <= a) begin
        nl++;
        if (!blocked(s)) ev_q.push_back('{lc, 0, s});
        else if (ff == INF) ff = lc;
      end
      if (lc + 1 <= a) begin
        ns++;
        if (!blocked(d)) ev_q.push_back('{lc + 1, 1, d});
        else if (ff == INF) ff = lc + 1;
      end
    end
    if (t0 + 1 + 2 * n <= a) ev_q.push_back('{t0 + 1 + 2 * n, 2, (src + n) % 4096});
    apply_model(src, dst, nl, ns);
    mv_t0 = t0;
    mv_len = n;
    mv_fault_from = ff;
    mv_abort = a;
    bus.start = 1'b1;
    bus.addressin = 12'(src);
    bus.destin = 12'(dst);
    bus.len = 6'(n);
    end_cyc = (a == INF) ? t0 + 2 + 2 * n : a + 2;
    while (cyc < end_cyc) begin
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      bus.addressin = 12'($urandom);
      bus.destin = 12'($urandom);
      bus.len = 6'($urandom);
      reset = 1'b0;
      if (mid_off >= 0 && cyc == t0 + mid_off) bus.start = 1'b1;
      if (cyc == a) reset = 1'b1;
    end
    check("events_pending", ev_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) bad++;
    check("mem_mismatch_words", bad, 0);
  endtask

  initial begin
    int src;
    int dst;
    int n;
    int ab;
    int mid;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.addressin = '0;
    bus.destin = '0;
    bus.len = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'($urandom);
      exp_mem[i] = mem[i];
    end
    @(negedge clk);
    #1;
    mv_abort = cyc;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;

    run_move(100, 300, 10, -1, -1);
    run_move(100, 500, 0, -1, -1);
    run_move(4094, 10, 4, -1, -1);
    run_move(500, 700, 8, -1, 4);
    run_move(1000, 1200, 10, 5, -1);
    run_move(2000, 2010, 5, -1, -1);
    run_move(3995, 3990, 7, -1, 3);

    for (int k = 0; k < 25; k++) begin
      src = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3980, 4095)) : int'($urandom_range(0, 4095));
      dst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3980, 4095)) : int'($urandom_range(0, 4095));
      n   = int'($urandom_range(0, 63));
      mid = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * n)) : -1;
      ab  = (n > 0 && (k % 6) == 5) ? int'($urandom_range(1, 2 * n)) : -1;
      run_move(src, dst, n, ab, mid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
